// File: rtl/sp_step_unit_pkg.sv
// Shared processor constants and command decode for the stack-pointer unit.
//   ADDR_W       default pointer/address width
//   STEP_WORD    bytes per stack word
//   STACK_TOP    pointer value of an empty stack (highest legal)
//   STACK_BOTTOM pointer value of a full stack (lowest legal)
package sp_step_unit_pkg;

  localparam int ADDR_W    = 10;
  localparam int STEP_WORD = 2;
  localparam logic [ADDR_W-1:0] STACK_TOP    = 10'h3FE;
  localparam logic [ADDR_W-1:0] STACK_BOTTOM = 10'h300;

  typedef enum logic [2:0] {
    CMD_IDLE,
    CMD_LOAD,
    CMD_REPL,   // push and pop together: replace top, pointer unchanged
    CMD_PUSH,
    CMD_POP
  } cmd_e;

  // Resolve the per-cycle command: load > push&pop > push > pop > idle.
  function automatic cmd_e decode_cmd(input logic push, input logic pop, input logic load);
    if (load)             return CMD_LOAD;
    else if (push && pop) return CMD_REPL;
    else if (push)        return CMD_PUSH;
    else if (pop)         return CMD_POP;
    else                  return CMD_IDLE;
  endfunction

endpackage

// File: rtl/sp_step_unit_if.sv
// Command/status bundle of the stack-pointer unit.
//   master: issues push/pop/load/clear_err, observes pointer and flags
//   slave : the unit itself
interface sp_step_unit_if import sp_step_unit_pkg::*; #(
  parameter int WIDTH = ADDR_W
);
  logic             push;
  logic             pop;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             clear_err;
  logic [WIDTH-1:0] sp;
  logic [WIDTH-1:0] push_addr;
  logic [WIDTH-1:0] depth;
  logic             ack;
  logic             overflow;
  logic             underflow;
  logic             err_sticky;

  modport master (
    output push, pop, load, load_value, clear_err,
    input  sp, push_addr, depth, ack, overflow, underflow, err_sticky
  );

  modport slave (
    input  push, pop, load, load_value, clear_err,
    output sp, push_addr, depth, ack, overflow, underflow, err_sticky
  );
endinterface

// File: rtl/sp_step_unit_addr_step_calc.sv
// Combinational pointer step: ptr -/+ STEP (mod 2^WIDTH) and bound checks.
//   ptr      : current pointer
//   dec/inc  : ptr - STEP / ptr + STEP, wrapped
//   below_lo : ptr - STEP would fall under LIMIT_LO (a borrow counts as below)
//   above_hi : ptr + STEP would exceed LIMIT_HI (a carry counts as above)
module addr_step_calc import sp_step_unit_pkg::*; #(
  parameter int               WIDTH    = ADDR_W,
  parameter int               STEP     = STEP_WORD,
  parameter logic [WIDTH-1:0] LIMIT_LO = STACK_BOTTOM,
  parameter logic [WIDTH-1:0] LIMIT_HI = STACK_TOP
) (
  input  logic [WIDTH-1:0] ptr,
  output logic [WIDTH-1:0] dec,
  output logic [WIDTH-1:0] inc,
  output logic             below_lo,
  output logic             above_hi
);
  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

  logic [WIDTH:0] dec_x, inc_x;

  // One extra bit keeps the borrow/carry visible to the compares.
  assign dec_x = {1'b0, ptr} - STEP_X;
  assign inc_x = {1'b0, ptr} + STEP_X;

  assign dec = dec_x[WIDTH-1:0];
  assign inc = inc_x[WIDTH-1:0];

  assign below_lo = dec_x[WIDTH] | (dec_x < {1'b0, LIMIT_LO});
  assign above_hi = inc_x > {1'b0, LIMIT_HI};
endmodule

// File: rtl/sp_step_unit.sv
// Registered stack-pointer / address-step unit.
//   clk, rst_n : clock, synchronous active-low reset
//   bus.slave  : push/pop/load/load_value/clear_err in;
//                sp, push_addr (comb sp-STEP), depth, ack/overflow/underflow
//                pulses and err_sticky out
// WRAP=1 steps modulo 2^WIDTH with no faults; WRAP=0 holds and faults at limits.
module sp_step_unit import sp_step_unit_pkg::*; #(
  parameter int               WIDTH       = ADDR_W,
  parameter int               STEP        = STEP_WORD,
  parameter logic [WIDTH-1:0] RESET_VALUE = STACK_TOP,
  parameter logic [WIDTH-1:0] LIMIT_LO    = STACK_BOTTOM,
  parameter logic [WIDTH-1:0] LIMIT_HI    = STACK_TOP,
  parameter bit               WRAP        = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  sp_step_unit_if.slave  bus
);
  logic [WIDTH-1:0] sp_q, sp_nxt;
  logic [WIDTH-1:0] depth_q, depth_nxt;
  logic             ack_q, ack_nxt;
  logic             ovf_q, ovf_nxt;
  logic             unf_q, unf_nxt;
  logic             err_q, err_nxt;
  logic [WIDTH-1:0] sp_dec, sp_inc;
  logic             below_lo, above_hi;
  cmd_e             cmd;

  addr_step_calc #(
    .WIDTH(WIDTH), .STEP(STEP), .LIMIT_LO(LIMIT_LO), .LIMIT_HI(LIMIT_HI)
  ) u_calc (
    .ptr(sp_q), .dec(sp_dec), .inc(sp_inc), .below_lo(below_lo), .above_hi(above_hi)
  );

  assign cmd = decode_cmd(bus.push, bus.pop, bus.load);

  always_comb begin
    sp_nxt    = sp_q;
    depth_nxt = depth_q;
    ack_nxt   = 1'b0;
    ovf_nxt   = 1'b0;
    unf_nxt   = 1'b0;
    case (cmd)
      CMD_LOAD: begin
        sp_nxt    = bus.load_value;
        depth_nxt = '0;
        ack_nxt   = 1'b1;
      end
      CMD_REPL: ack_nxt = 1'b1;
      CMD_PUSH: begin
        if (!WRAP && below_lo) begin
          ovf_nxt = 1'b1;
        end else begin
          sp_nxt    = sp_dec;
          depth_nxt = (&depth_q) ? depth_q : depth_q + WIDTH'(1);
          ack_nxt   = 1'b1;
        end
      end
      CMD_POP: begin
        if (!WRAP && above_hi) begin
          unf_nxt = 1'b1;
        end else begin
          sp_nxt    = sp_inc;
          depth_nxt = (depth_q == '0) ? depth_q : depth_q - WIDTH'(1);
          ack_nxt   = 1'b1;
        end
      end
      default: ;
    endcase
    // A fault in the same cycle as clear_err keeps the error set.
    err_nxt = ovf_nxt | unf_nxt | (err_q & ~bus.clear_err);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp_q    <= RESET_VALUE;
      depth_q <= '0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sp_q    <= sp_nxt;
      depth_q <= depth_nxt;
      ack_q   <= ack_nxt;
      ovf_q   <= ovf_nxt;
      unf_q   <= unf_nxt;
      err_q   <= err_nxt;
    end
  end

  assign bus.sp         = sp_q;
  assign bus.push_addr  = sp_dec;
  assign bus.depth      = depth_q;
  assign bus.ack        = ack_q;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = unf_q;
  assign bus.err_sticky = err_q;
endmodule

// File: doc/sp_step_unit.md
Name: sp_step_unit

Overview:
- Parametrised, registered stack-pointer / address-step unit for the processor datapath. Generalises the fixed 10-bit "minus 2" adjuster.
- Holds a pointer register and steps it down on push and up on pop by a parametrised STEP. Also supports load.
- Bounds checking against parametrised limits, with selectable wrap or hold-and-fault mode, sticky error, and an occupancy counter.
- Feeds the data-memory address mux and the control unit's exception logic.

Parameters:
WIDTH, 10, pointer/address width in bits
STEP, 2, bytes per stack word; push subtracts, pop adds
RESET_VALUE, 10'h3FE, pointer value after reset (empty stack, top of region)
LIMIT_LO, 10'h300, lowest legal pointer value (stack full)
LIMIT_HI, 10'h3FE, highest legal pointer value (stack empty)
WRAP, 0, 1 = modulo-2^WIDTH stepping, no bound faults; 0 = hold and fault at limits

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  synchronous active-low reset
push  input  1  decrement pointer by STEP this cycle
pop  input  1  increment pointer by STEP this cycle
load  input  1  write load_value into pointer
load_value  input  WIDTH  new pointer value
clear_err  input  1  clear err_sticky
sp  output  WIDTH  registered current pointer
push_addr  output  WIDTH  combinational sp - STEP, modulo 2^WIDTH (write address for a pending push)
depth  output  WIDTH  registered occupancy: pushes minus pops since reset/load
ack  output  1  registered one-cycle pulse: previous-cycle command accepted
overflow  output  1  registered one-cycle pulse: push refused at LIMIT_LO
underflow  output  1  registered one-cycle pulse: pop refused at LIMIT_HI
err_sticky  output  1  registered; set on any overflow/underflow, held until clear_err or reset

Behaviour:
- Reset: one clock, synchronous, active-low (rst_n sampled low at a clk edge). Values after reset: sp=RESET_VALUE, depth=0, ack=0, overflow=0, underflow=0, err_sticky=0. All commands in a reset cycle are ignored.
- Latency: every registered output reflects a command on the clock edge that samples it; the result is visible the following cycle. push_addr tracks sp combinationally, zero latency.
- Command priority each cycle: load > (push & pop) > push > pop > idle.
- load:
  - sp <= load_value; depth <= 0; ack=1.
  - No bound check; software owns the loaded value.
- push & pop together: replace-top. sp and depth unchanged, ack=1, no fault.
- push:
  - WRAP=0 and sp - STEP < LIMIT_LO (compared in WIDTH+1 bits, so a borrow counts as below): sp held, depth held, overflow=1, ack=0, err_sticky<=1.
  - Otherwise: sp <= sp - STEP (mod 2^WIDTH); depth <= depth+1, saturating at all-ones; ack=1.
- pop:
  - WRAP=0 and sp + STEP > LIMIT_HI (WIDTH+1-bit compare, carry counts as above): sp held, underflow=1, ack=0, err_sticky<=1.
  - Otherwise: sp <= sp + STEP (mod 2^WIDTH); depth <= depth-1, saturating at 0; ack=1.
- WRAP=1: limits ignored. overflow and underflow stay 0.
- clear_err: err_sticky<=0, unless a fault occurs in the same cycle; set wins.
- ack, overflow and underflow are single-cycle pulses; a held command produces a pulse every cycle.
- No FSM beyond the pointer, depth and flag registers. Arithmetic is unsigned with explicit WIDTH+1 extension for the compares.

Decomposition:
- Shared processor package holds WIDTH's default (ADDR_W=10), STEP_WORD=2, and the stack-region constants STACK_TOP and STACK_BOTTOM. Instances take their parameters from these.
- One natural sub-module, addr_step_calc: combinational, outputs sum/difference by STEP plus the out-of-bounds bits. Reused by the PC path; this block adds the registers and policy.

Test Plan:
1. Reset, then push one cycle -> next cycle sp=0x3FC, depth=1, ack=1; push_addr=0x3FC before the push and 0x3FA after.
2. Pop straight after reset (sp=0x3FE) -> underflow=1 for one cycle, sp=0x3FE, err_sticky=1; then clear_err one cycle -> err_sticky=0.
3. Load 0x302, push -> sp=0x300, ack=1; push again -> overflow=1, sp=0x300, depth=1; clear_err and push same cycle -> err_sticky stays 1.
4. Load 0x3F0, then push and pop asserted together -> sp=0x3F0, depth=0, ack=1, no faults.
5. Instance with WRAP=1, LIMIT_LO=0: load 0x000, push -> sp=0x3FE, overflow=0; then pop -> sp=0x000.
6. Mid-sequence (sp=0x3F8, depth=3), rst_n low for one cycle with push asserted -> sp=0x3FE, depth=0, all flags 0, push ignored.
